// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared state type, parity mode constants and parity helper for the serial parity link
package parity_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAP} ptx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Narrower words are zero-extended; extra zeros leave the parity unchanged.
    function automatic logic par_bit(input logic [63:0] data, input logic mode);
        return (^data) ^ mode;
    endfunction

endpackage

// File: rtl/parity_tx.sv
// rtl/parity_tx.sv - serial parity-frame transmitter, LSB-first data then one parity bit then a valid-low gap
// Optional feature: PARITY_TX_ERR_INJECT_EN adds err_inject to invert the parity bit of a frame.
module parity_tx
    import parity_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
`ifdef PARITY_TX_ERR_INJECT_EN
    input  logic             err_inject,
`endif
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    input  logic             mode,
    output logic             ready,
    output logic             serial_out,
    output logic             valid_out,
    output logic             done
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    ptx_state_t       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             acc_q, acc_d;
    logic             err_q, err_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic             ready_q, ready_d;
    logic             serial_q, serial_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            acc_q     <= 1'b0;
            err_q     <= 1'b0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            ready_q   <= 1'b1;
            serial_q  <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            acc_q     <= acc_d;
            err_q     <= err_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            ready_q   <= ready_d;
            serial_q  <= serial_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    // Outputs are registered, so each branch computes what the next cycle shows.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        acc_d     = acc_q;
        err_d     = err_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        ready_d   = 1'b0;
        serial_d  = 1'b0;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (load && ready_q) begin
                    state_d   = SHIFT;
                    serial_d  = data_in[0];
                    valid_d   = 1'b1;
                    shreg_d   = data_in >> 1;
                    acc_d     = (mode == PAR_ODD) ^ data_in[0];
                    bit_cnt_d = '0;
`ifdef PARITY_TX_ERR_INJECT_EN
                    err_d     = err_inject;
`else
                    err_d     = 1'b0;
`endif
                end else begin
                    ready_d = 1'b1;
                end
            end
            SHIFT: begin
                valid_d = 1'b1;
                if (bit_cnt_q == BIT_LAST) begin
                    state_d  = PARITY;
                    serial_d = acc_q ^ err_q;
                    done_d   = 1'b1;
                end else begin
                    serial_d  = shreg_q[0];
                    acc_d     = acc_q ^ shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            PARITY: begin
                state_d   = GAP;
                gap_cnt_d = '0;
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready      = ready_q;
    assign serial_out = serial_q;
    assign valid_out  = valid_q;
    assign done       = done_q;

endmodule

// File: tb/tb_parity_tx.sv
// tb/tb_parity_tx.sv - directed self-checking bench for parity_tx (GAP_CYCLES 1 and 3 instances)
module tb_parity_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] data_in;
    logic       load;
    logic       mode;
`ifdef PARITY_TX_ERR_INJECT_EN
    logic       err_inject;
`endif
    logic ready1, serial1, valid1, done1;
    logic ready3, serial3, valid3, done3;

    int n_pass  = 0;
    int n_total = 0;

    parity_tx #(.WIDTH(8), .GAP_CYCLES(1)) dut1 (
        .clk(clk),
        .reset(reset),
`ifdef PARITY_TX_ERR_INJECT_EN
        .err_inject(err_inject),
`endif
        .data_in(data_in),
        .load(load),
        .mode(mode),
        .ready(ready1),
        .serial_out(serial1),
        .valid_out(valid1),
        .done(done1)
    );

    parity_tx #(.WIDTH(8), .GAP_CYCLES(3)) dut3 (
        .clk(clk),
        .reset(reset),
`ifdef PARITY_TX_ERR_INJECT_EN
        .err_inject(err_inject),
`endif
        .data_in(data_in),
        .load(load),
        .mode(mode),
        .ready(ready3),
        .serial_out(serial3),
        .valid_out(valid3),
        .done(done3)
    );

    logic [7:0] vec_data [5] = '{8'hA5, 8'hA5, 8'h07, 8'h00, 8'hFF};
    logic       vec_mode [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [8:0] vec_bits [5] = '{9'h0A5, 9'h1A5, 9'h107, 9'h100, 9'h0FF};

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        load  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Sends one frame on dut1 and captures it; compares nothing itself.
    task automatic run_frame(input logic [7:0] d, input logic m, input bit glitch,
                             output logic [8:0] bits, output int vlen, output int done_cnt,
                             output int done_at, output int gap, output bit to);
        int w;
        bits = '0; vlen = 0; done_cnt = 0; done_at = 0; gap = 0; to = 1'b0;
        w = 0;
        @(negedge clk);
        while (!ready1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!ready1) to = 1'b1;
        data_in = d;
        mode    = m;
        load    = 1'b1;
        @(posedge clk);
        #1;
        load    = 1'b0;
        data_in = ~d;
        mode    = ~m;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bits[i] = serial1;
            if (valid1) vlen++;
            if (done1) begin
                done_cnt++;
                done_at = i + 1;
            end
            if (glitch && i == 2) begin
                load    = 1'b1;
                data_in = 8'hFF;
                mode    = ~m;
            end
            if (glitch && i == 5) load = 1'b0;
        end
        w = 0;
        @(negedge clk);
        while (!ready1 && w < 20) begin
            if (!valid1 && !serial1 && !done1) gap++;
            @(negedge clk);
            w++;
        end
        if (!ready1) to = 1'b1;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        load    = 1'b0;
        data_in = 8'h00;
        mode    = 1'b0;
`ifdef PARITY_TX_ERR_INJECT_EN
        err_inject = 1'b0;
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_total++; if (ready1 !== 1'b1) $display("FAIL reset_ready got=%b exp=1", ready1); else n_pass++;
        n_total++; if (serial1 !== 1'b0) $display("FAIL reset_serial got=%b exp=0", serial1); else n_pass++;
        n_total++; if (valid1 !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid1); else n_pass++;
        n_total++; if (done1 !== 1'b0) $display("FAIL reset_done got=%b exp=0", done1); else n_pass++;
        n_total++; if (ready3 !== 1'b1) $display("FAIL reset_ready_g3 got=%b exp=1", ready3); else n_pass++;
    endtask

    task automatic test_frames();
        logic [8:0] bits;
        int vlen, dcnt, dat, gap;
        bit to;
        for (int k = 0; k < 5; k++) begin
            run_frame(vec_data[k], vec_mode[k], 1'b0, bits, vlen, dcnt, dat, gap, to);
            n_total++; if (bits !== vec_bits[k]) $display("FAIL frame%0d_bits got=%h exp=%h", k, bits, vec_bits[k]); else n_pass++;
            n_total++; if (vlen !== 9) $display("FAIL frame%0d_valid_len got=%0d exp=9", k, vlen); else n_pass++;
            n_total++; if (dcnt !== 1) $display("FAIL frame%0d_done_count got=%0d exp=1", k, dcnt); else n_pass++;
            n_total++; if (dat !== 9) $display("FAIL frame%0d_done_cycle got=%0d exp=9", k, dat); else n_pass++;
            n_total++; if (gap !== 1) $display("FAIL frame%0d_gap got=%0d exp=1", k, gap); else n_pass++;
            n_total++; if (to !== 1'b0) $display("FAIL frame%0d_timeout got=%b exp=0", k, to); else n_pass++;
            n_total++; if (((^bits) == vec_mode[k]) !== 1'b1) $display("FAIL frame%0d_parity_ok got=0 exp=1", k); else n_pass++;
        end
    endtask

    task automatic test_back_to_back(input int g);
        logic vv [1:30];
        logic rr [1:30];
        logic ss [1:30];
        logic [8:0] b1, b2;
        int v1, v2, gl, rc;
        pulse_reset();
        data_in = 8'h3C;
        mode    = 1'b0;
        load    = 1'b1;
        @(posedge clk);
        #1;
        data_in = 8'h81;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            vv[i] = (g == 1) ? valid1  : valid3;
            rr[i] = (g == 1) ? ready1  : ready3;
            ss[i] = (g == 1) ? serial1 : serial3;
        end
        load = 1'b0;
        b1 = '0; b2 = '0; v1 = 0; v2 = 0; gl = 0; rc = 0;
        for (int i = 0; i < 9; i++) begin
            b1[i] = ss[1 + i];
            b2[i] = ss[11 + g + i];
            if (vv[1 + i]) v1++;
            if (vv[11 + g + i]) v2++;
        end
        for (int i = 10; i <= 9 + g; i++) if (!vv[i] && !rr[i]) gl++;
        for (int i = 1; i <= 19 + g; i++) if (rr[i]) rc++;
        n_total++; if (b1 !== 9'h03C) $display("FAIL b2b_g%0d_bits1 got=%h exp=03c", g, b1); else n_pass++;
        n_total++; if (b2 !== 9'h081) $display("FAIL b2b_g%0d_bits2 got=%h exp=081", g, b2); else n_pass++;
        n_total++; if (v1 !== 9) $display("FAIL b2b_g%0d_valid1 got=%0d exp=9", g, v1); else n_pass++;
        n_total++; if (v2 !== 9) $display("FAIL b2b_g%0d_valid2 got=%0d exp=9", g, v2); else n_pass++;
        n_total++; if (gl !== g) $display("FAIL b2b_g%0d_gap got=%0d exp=%0d", g, gl, g); else n_pass++;
        n_total++; if (rc !== 1) $display("FAIL b2b_g%0d_ready_cycles got=%0d exp=1", g, rc); else n_pass++;
        n_total++; if (rr[10 + g] !== 1'b1) $display("FAIL b2b_g%0d_ready_pos got=%b exp=1", g, rr[10 + g]); else n_pass++;
        n_total++; if ((^b1) !== 1'b0 || (^b2) !== 1'b0) $display("FAIL b2b_g%0d_parity_ok got=0 exp=1", g); else n_pass++;
        pulse_reset();
    endtask

    task automatic test_reset_midframe();
        int vc, dc;
        @(negedge clk);
        data_in = 8'hA5;
        mode    = 1'b0;
        load    = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_total++; if (valid1 !== 1'b1) $display("FAIL midrst_valid_before got=%b exp=1", valid1); else n_pass++;
        reset = 1'b1;
        #1;
        n_total++; if (valid1 !== 1'b0) $display("FAIL midrst_valid got=%b exp=0", valid1); else n_pass++;
        n_total++; if (serial1 !== 1'b0) $display("FAIL midrst_serial got=%b exp=0", serial1); else n_pass++;
        n_total++; if (done1 !== 1'b0) $display("FAIL midrst_done got=%b exp=0", done1); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_total++; if (ready1 !== 1'b1) $display("FAIL midrst_ready got=%b exp=1", ready1); else n_pass++;
        vc = 0; dc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (valid1) vc++;
            if (done1) dc++;
        end
        n_total++; if (vc !== 0) $display("FAIL midrst_no_valid got=%0d exp=0", vc); else n_pass++;
        n_total++; if (dc !== 0) $display("FAIL midrst_no_parity got=%0d exp=0", dc); else n_pass++;
    endtask

    task automatic test_load_ignored();
        logic [8:0] bits;
        int vlen, dcnt, dat, gap, vc;
        bit to;
        run_frame(8'h07, 1'b0, 1'b1, bits, vlen, dcnt, dat, gap, to);
        n_total++; if (bits !== 9'h107) $display("FAIL ignore_bits got=%h exp=107", bits); else n_pass++;
        n_total++; if (vlen !== 9) $display("FAIL ignore_valid_len got=%0d exp=9", vlen); else n_pass++;
        n_total++; if (to !== 1'b0) $display("FAIL ignore_timeout got=%b exp=0", to); else n_pass++;
        vc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (valid1 || !ready1) vc++;
        end
        n_total++; if (vc !== 0) $display("FAIL ignore_not_queued got=%0d exp=0", vc); else n_pass++;
    endtask

`ifdef PARITY_TX_ERR_INJECT_EN
    task automatic test_err_inject();
        logic [8:0] bits;
        int vlen, dcnt, dat, gap;
        bit to;
        err_inject = 1'b1;
        run_frame(8'hA5, 1'b0, 1'b0, bits, vlen, dcnt, dat, gap, to);
        err_inject = 1'b0;
        n_total++; if (bits !== 9'h1A5) $display("FAIL errinj_bits got=%h exp=1a5", bits); else n_pass++;
        n_total++; if (((^bits) == 1'b0) !== 1'b0) $display("FAIL errinj_parity_ok got=1 exp=0"); else n_pass++;
        run_frame(8'hA5, 1'b0, 1'b0, bits, vlen, dcnt, dat, gap, to);
        n_total++; if (bits !== 9'h0A5) $display("FAIL errinj_clear_bits got=%h exp=0a5", bits); else n_pass++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frames();
        test_back_to_back(1);
        test_back_to_back(3);
        test_reset_midframe();
        test_load_ignored();
`ifdef PARITY_TX_ERR_INJECT_EN
        test_err_inject();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
